glove_tracker: RTL and testbench

GLOVE_TRACKER -- requirements
Module: glove_tracker

---
 rtl/glove_pkg.sv | 19 +
 rtl/glove_debounce.sv | 43 ++++
 rtl/glove_tracker.sv | 130 +++++++++++++
 tb/tb_glove_tracker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glove_pkg.sv
// Shared types and sizing for the glove position tracker.
// Imported by glove_tracker; holds the tracking-state enum and window geometry.
package glove_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        LOST  = 2'd2
    } glove_state_t;

    localparam int unsigned WINDOW_LEN  = 4;
    localparam int unsigned WINDOW_LOG2 = 2;
    localparam int unsigned SUM_W       = 18;

    function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/glove_debounce.sv
// Two-flop synchronizer plus tick-based debounce for the glove flex sensor.
// A new level is adopted only after it differs from the current one for DEBOUNCE_TICKS ticks.
module glove_debounce #(
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level
);

    localparam int unsigned CNT_W = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS + 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (tick) begin
                if (sync_b != level) begin
                    if (cnt == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                        level <= sync_b;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/glove_tracker.sv
// Glove position tracker: 4-entry moving average with timeout and debounced closed level.
// Define GLOVE_OUTLIER_REJECT_EN to enable per-axis outlier rejection.
module glove_tracker
    import glove_pkg::*;
#(
    parameter int unsigned MAX_JUMP       = 200,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned TIMEOUT_TICKS  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        sample_valid,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic        sample_closed,
    output logic [15:0] glovex,
    output logic [15:0] glovey,
    output logic        glove_closed,
    output logic        pos_valid
);

    localparam int unsigned TO_W = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS + 1);

    glove_state_t           state;
    logic [15:0]            win_x [WINDOW_LEN];
    logic [15:0]            win_y [WINDOW_LEN];
    logic [WINDOW_LOG2-1:0] wr_ptr;
    logic [SUM_W-1:0]       sum_x;
    logic [SUM_W-1:0]       sum_y;
    logic [SUM_W-1:0]       upd_sum_x;
    logic [SUM_W-1:0]       upd_sum_y;
    logic [TO_W-1:0]        to_cnt;
    logic                   outlier;
    logic                   force_preload;
    logic                   do_preload;
    logic                   do_accept;

    // wr_ptr always addresses the oldest entry
    assign upd_sum_x = sum_x - SUM_W'(win_x[wr_ptr]) + SUM_W'(sample_x);
    assign upd_sum_y = sum_y - SUM_W'(win_y[wr_ptr]) + SUM_W'(sample_y);

`ifdef GLOVE_OUTLIER_REJECT_EN
    localparam logic [15:0] JUMP_LIM = 16'(MAX_JUMP);

    logic [1:0] rej_cnt;

    assign outlier = (abs_diff(sample_x, glovex) > JUMP_LIM) ||
                     (abs_diff(sample_y, glovey) > JUMP_LIM);
    // A fourth consecutive outlier is taken as a genuine relocation
    assign force_preload = outlier && (rej_cnt == 2'd3);
`else
    assign outlier       = 1'b0;
    assign force_preload = 1'b0;
`endif

    assign do_preload = sample_valid && ((state != TRACK) || force_preload);
    assign do_accept  = sample_valid && (state == TRACK) && !outlier;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            sum_x     <= '0;
            sum_y     <= '0;
            to_cnt    <= '0;
            glovex    <= '0;
            glovey    <= '0;
            pos_valid <= 1'b0;
            for (int i = 0; i < WINDOW_LEN; i++) begin
                win_x[i] <= '0;
                win_y[i] <= '0;
            end
`ifdef GLOVE_OUTLIER_REJECT_EN
            rej_cnt   <= '0;
`endif
        end else begin
            if (do_preload) begin
                for (int i = 0; i < WINDOW_LEN; i++) begin
                    win_x[i] <= sample_x;
                    win_y[i] <= sample_y;
                end
                sum_x     <= {sample_x, 2'b00};
                sum_y     <= {sample_y, 2'b00};
                wr_ptr    <= '0;
                glovex    <= sample_x;
                glovey    <= sample_y;
                state     <= TRACK;
                pos_valid <= 1'b1;
                to_cnt    <= '0;
            end else if (do_accept) begin
                win_x[wr_ptr] <= sample_x;
                win_y[wr_ptr] <= sample_y;
                wr_ptr        <= wr_ptr + 1'b1;
                sum_x         <= upd_sum_x;
                sum_y         <= upd_sum_y;
                glovex        <= upd_sum_x[SUM_W-1:2];
                glovey        <= upd_sum_y[SUM_W-1:2];
                to_cnt        <= '0;
            end else if ((state == TRACK) && tick) begin
                // Rejected samples fall through here so they never refresh the timeout
                if (to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
                    state     <= LOST;
                    pos_valid <= 1'b0;
                    to_cnt    <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
`ifdef GLOVE_OUTLIER_REJECT_EN
            if (do_preload || do_accept) begin
                rej_cnt <= '0;
            end else if (sample_valid && (state == TRACK) && outlier) begin
                rej_cnt <= rej_cnt + 1'b1;
            end
`endif
        end
    end

    glove_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .raw   (sample_closed),
        .level (glove_closed)
    );

endmodule

// File: tb/tb_glove_tracker.sv
// Scoreboard bench for glove_tracker: a queue-based moving-average model predicts every
// sample/tick response; a monitor pops and compares. Honours GLOVE_OUTLIER_REJECT_EN.
module tb_glove_tracker;

    localparam int MAX_JUMP       = 200;
    localparam int DEBOUNCE_TICKS = 4;
    localparam int TIMEOUT_TICKS  = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_x = '0;
    logic [15:0] sample_y = '0;
    logic        sample_closed = 1'b0;
    logic [15:0] glovex;
    logic [15:0] glovey;
    logic        glove_closed;
    logic        pos_valid;

    glove_tracker #(
        .MAX_JUMP       (MAX_JUMP),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .TIMEOUT_TICKS  (TIMEOUT_TICKS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .sample_valid  (sample_valid),
        .sample_x      (sample_x),
        .sample_y      (sample_y),
        .sample_closed (sample_closed),
        .glovex        (glovex),
        .glovey        (glovey),
        .glove_closed  (glove_closed),
        .pos_valid     (pos_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int v;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    // Reference model: last four accepted samples, oldest first
    int mqx[$];
    int mqy[$];
    int gx = 0;
    int gy = 0;
    bit mtrack = 1'b0;
    int mto = 0;
    int mrej = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic model_step(input bit sv, input int x, input int y, input bit tk);
        bit took = 1'b0;
        bit outl = 1'b0;
        if (sv) begin
`ifdef GLOVE_OUTLIER_REJECT_EN
            outl = (iabs(x - gx) > MAX_JUMP) || (iabs(y - gy) > MAX_JUMP);
`endif
            if (!mtrack || (outl && mrej == 3)) begin
                mqx = '{x, x, x, x};
                mqy = '{y, y, y, y};
                mtrack = 1'b1;
                took = 1'b1;
            end else if (outl) begin
                mrej++;
            end else begin
                void'(mqx.pop_front());
                void'(mqy.pop_front());
                mqx.push_back(x);
                mqy.push_back(y);
                took = 1'b1;
            end
            if (took) begin
                gx = mqx.sum() / 4;
                gy = mqy.sum() / 4;
                mto = 0;
                mrej = 0;
            end
        end
        if (tk && mtrack && !took) begin
            mto++;
            if (mto == TIMEOUT_TICKS) begin
                mtrack = 1'b0;
                mto = 0;
            end
        end
    endtask

    // One clock of stimulus; returns at posedge+1 with inputs released
    task automatic cyc(input bit sv, input int x, input int y, input bit tk);
        exp_t e;
        @(negedge clk);
        sample_valid = sv;
        sample_x = 16'(x);
        sample_y = 16'(y);
        tick = tk;
        model_step(sv, x, y, tk);
        if (sv || tk) begin
            e.x = gx;
            e.y = gy;
            e.v = int'(mtrack);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        sample_closed = 1'b0;
        #1;
        chk({tag, "_x"}, int'(glovex), 0);
        chk({tag, "_y"}, int'(glovey), 0);
        chk({tag, "_valid"}, int'(pos_valid), 0);
        chk({tag, "_closed"}, int'(glove_closed), 0);
        mqx.delete();
        mqy.delete();
        gx = 0;
        gy = 0;
        mtrack = 1'b0;
        mto = 0;
        mrej = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: every sample or tick cycle has a predicted response
    always @(posedge clk) begin
        if (reset && (sample_valid || tick)) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow: got response with no prediction at %0t",
                         $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_glovex", int'(glovex), mon_e.x);
                chk("sb_glovey", int'(glovey), mon_e.y);
                chk("sb_pos_valid", int'(pos_valid), mon_e.v);
            end
        end
    end

    initial begin
        #1;
        reset = 1'b0;
        #2;
        chk("rst_glovex", int'(glovex), 0);
        chk("rst_glovey", int'(glovey), 0);
        chk("rst_pos_valid", int'(pos_valid), 0);
        chk("rst_closed", int'(glove_closed), 0);
        @(negedge clk);
        reset = 1'b1;

        // Debounce in IDLE: a two-tick pulse is filtered, a four-tick hold is adopted
        sample_closed = 1'b1;
        idle(3);
        cyc(1'b0, 0, 0, 1'b1);
        idle(2);
        cyc(1'b0, 0, 0, 1'b1);
        chk("db_pulse_tick2", int'(glove_closed), 0);
        sample_closed = 1'b0;
        idle(3);
        cyc(1'b0, 0, 0, 1'b1);
        chk("db_pulse_end", int'(glove_closed), 0);
        sample_closed = 1'b1;
        idle(3);
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b0, 0, 0, 1'b1);
            chk("db_hold_early", int'(glove_closed), 0);
            idle(2);
        end
        cyc(1'b0, 0, 0, 1'b1);
        chk("db_hold_tick4", int'(glove_closed), 1);

        // First sample preloads; following samples average in
        cyc(1'b1, 1000, 500, 1'b0);
        chk("first_x", int'(glovex), 1000);
        chk("first_y", int'(glovey), 500);
        chk("first_valid", int'(pos_valid), 1);
        cyc(1'b1, 1040, 500, 1'b0);
        chk("avg_1040", int'(glovex), 1010);
        cyc(1'b1, 1080, 500, 1'b0);
        chk("avg_1080", int'(glovex), 1030);
        cyc(1'b1, 1120, 500, 1'b0);
        chk("avg_1120", int'(glovex), 1060);
        cyc(1'b1, 1160, 500, 1'b0);
        chk("avg_1160", int'(glovex), 1100);

        do_reset("mid_track_rst");

        // Outlier boundary and forced relocation
        cyc(1'b1, 1000, 500, 1'b0);
        cyc(1'b1, 1201, 500, 1'b0);
`ifdef GLOVE_OUTLIER_REJECT_EN
        chk("outlier_1201", int'(glovex), 1000);
`else
        chk("outlier_1201", int'(glovex), 1050);
`endif
        do_reset("pre_reloc_rst");
        cyc(1'b1, 1000, 500, 1'b0);
        for (int k = 1; k <= 3; k++) cyc(1'b1, 1500, 500, 1'b0);
`ifdef GLOVE_OUTLIER_REJECT_EN
        chk("reloc_third", int'(glovex), 1000);
`else
        chk("reloc_third", int'(glovex), 1375);
`endif
        cyc(1'b1, 1500, 500, 1'b0);
        chk("reloc_fourth", int'(glovex), 1500);

        // Timeout after 32 idle ticks, then recovery
        do_reset("pre_timeout_rst");
        cyc(1'b1, 1000, 500, 1'b0);
        for (int t = 1; t <= TIMEOUT_TICKS; t++) begin
            idle(1);
            cyc(1'b0, 0, 0, 1'b1);
            if (t == TIMEOUT_TICKS - 1) chk("to_tick31_valid", int'(pos_valid), 1);
        end
        chk("to_tick32_valid", int'(pos_valid), 0);
        chk("to_hold_x", int'(glovex), 1000);
        cyc(1'b1, 1300, 600, 1'b0);
        chk("to_recover_x", int'(glovex), 1300);
        chk("to_recover_valid", int'(pos_valid), 1);

        // Randomized traffic, alternating busy and sparse phases
        for (int i = 0; i < 3000; i++) begin
            bit sv;
            bit tk;
            int span;
            int x;
            int y;
            if (i == 1500) do_reset("rand_rst");
            if (((i / 500) % 2) == 1) begin
                sv = ($urandom_range(0, 199) == 0);
                tk = ($urandom_range(0, 3) == 0);
            end else begin
                sv = ($urandom_range(0, 2) == 0);
                tk = ($urandom_range(0, 15) == 0);
            end
            span = ($urandom_range(0, 7) == 0) ? 3000 : 250;
            x = gx + int'($urandom_range(0, 2 * span)) - span;
            y = gy + int'($urandom_range(0, 2 * span)) - span;
            if (x < 0) x = 0;
            if (x > 65535) x = 65535;
            if (y < 0) y = 0;
            if (y > 65535) y = 65535;
            if ($urandom_range(0, 63) == 0) sample_closed = ~sample_closed;
            cyc(sv, x, y, tk);
        end

        idle(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
